// File: rtl/pipeline_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_scoreboard_pkg
//  Purpose  : Shared definitions for the pipeline hazard/forwarding scoreboard.
//             Holds the register index width, the tracked stage indices and
//             the forwarding-select encoding. Also provides the required-stage
//             helper used by the hazard check.
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_scoreboard_pkg;

    // Register index width (32-entry register file)
    localparam int c_reg_w   = 5;

    // Tracked stage indices after ID
    localparam int c_stg_ex  = 0;
    localparam int c_stg_mem = 1;
    localparam int c_stg_wb  = 2;

    // Forwarding select: 0 reads the register file; k+1 takes stage k's result
    localparam int c_fwd_rf  = 0;

    // First stage at which a producer's result can feed the ID consumer.
    // Branches compare in ID, so they need the value BR_EXTRA stages later.
    function automatic int required_stage(
        input logic is_load,
        input logic is_branch,
        input int   alu_ready,
        input int   load_ready,
        input int   br_extra
    );
        required_stage = (is_load ? load_ready : alu_ready) + (is_branch ? br_extra : 0);
    endfunction

endpackage : pipeline_scoreboard_pkg
`default_nettype wire

// File: rtl/pipeline_scoreboard_youngest_match.sv
`default_nettype none
// ============================================================================
//  Module   : sb_youngest_match
//  Purpose  : Combinational priority finder. For one ID source register it
//             finds the youngest (lowest index) tracked stage that will write
//             that register, and reports whether that producer is a load.
//  Ports    : src/use_src          - source register and its use flag
//             ent_valid/wr_en/
//             is_load/rd           - tracked entries, index 0 = youngest
//             hit, idx, hit_is_load - match found, its stage, its load flag
//  Revision : 1.0 - initial release
// ============================================================================
module sb_youngest_match #(
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int IDX_W = 2
) (
    input  logic [REG_W-1:0]            src,
    input  logic                        use_src,
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH-1:0]            ent_wr_en,
    input  logic [DEPTH-1:0]            ent_is_load,
    input  logic [DEPTH-1:0][REG_W-1:0] ent_rd,
    output logic                        hit,
    output logic [IDX_W-1:0]            idx,
    output logic                        hit_is_load
);

    logic [DEPTH-1:0] w_match;

    // $0 is hard-wired zero, so it never has a producer to forward from
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_match
            assign w_match[k] = use_src && (src != '0) && ent_valid[k] &&
                                ent_wr_en[k] && (ent_rd[k] == src);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match is the last one written
    always_comb begin
        hit         = 1'b0;
        idx         = '0;
        hit_is_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                hit         = 1'b1;
                idx         = IDX_W'(k);
                hit_is_load = ent_is_load[k];
            end
        end
    end

endmodule : sb_youngest_match
`default_nettype wire

// File: rtl/pipeline_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_scoreboard
//  Purpose  : Hazard/forwarding scoreboard for the in-order pipeline. Tracks
//             producers in the DEPTH stages after ID, stalls PC/IFID and
//             bubbles EX on load-use and branch-operand hazards, drives
//             per-operand forwarding selects and the IF/ID flush, and keeps
//             saturating stall/flush counters.
//  Ports    : clk, rst_n (async, active-low)
//             id_*        - instruction currently in ID
//             redirect    - ID resolved a taken branch/jump
//             ext_stall   - downstream busy, freeze the tracker
//             stall_o, bubble_o, flush_ifid - pipeline control
//             fwd_rs_sel, fwd_rt_sel        - 0 = regfile, k+1 = stage k
//             stage_valid                   - valid bit per tracked stage
//             stall_cnt, flush_cnt          - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_scoreboard
    import pipeline_scoreboard_pkg::*;
#(
    parameter int DEPTH      = c_stg_wb + 1,
    parameter int REG_W      = c_reg_w,
    parameter int ALU_READY  = c_stg_ex,
    parameter int LOAD_READY = c_stg_mem,
    parameter int BR_EXTRA   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_rs,
    input  logic [REG_W-1:0]           id_rt,
    input  logic                       id_use_rs,
    input  logic                       id_use_rt,
    input  logic                       id_wr_en,
    input  logic [REG_W-1:0]           id_wr_rd,
    input  logic                       id_is_load,
    input  logic                       id_is_branch,
    input  logic                       redirect,
    input  logic                       ext_stall,
    output logic                       stall_o,
    output logic                       bubble_o,
    output logic                       flush_ifid,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs_sel,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rt_sel,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int c_sel_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Tracked entries, index 0 = EX (youngest)
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0]            r_wr_en;
    logic [DEPTH-1:0]            r_is_load;
    logic [DEPTH-1:0][REG_W-1:0] r_rd;
    logic [CNT_W-1:0]            r_stall_cnt;
    logic [CNT_W-1:0]            r_flush_cnt;

    logic               w_rs_hit, w_rt_hit;
    logic               w_rs_ld,  w_rt_ld;
    logic [c_idx_w-1:0] w_rs_idx, w_rt_idx;
    int                 w_rs_req, w_rt_req;
    logic               w_rs_haz, w_rt_haz;
    logic               w_haz;
    logic               w_accept;

    sb_youngest_match #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .IDX_W (c_idx_w)
    ) u_match_rs (
        .src         (id_rs),
        .use_src     (id_use_rs),
        .ent_valid   (r_valid),
        .ent_wr_en   (r_wr_en),
        .ent_is_load (r_is_load),
        .ent_rd      (r_rd),
        .hit         (w_rs_hit),
        .idx         (w_rs_idx),
        .hit_is_load (w_rs_ld)
    );

    sb_youngest_match #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .IDX_W (c_idx_w)
    ) u_match_rt (
        .src         (id_rt),
        .use_src     (id_use_rt),
        .ent_valid   (r_valid),
        .ent_wr_en   (r_wr_en),
        .ent_is_load (r_is_load),
        .ent_rd      (r_rd),
        .hit         (w_rt_hit),
        .idx         (w_rt_idx),
        .hit_is_load (w_rt_ld)
    );

    // A match is only a hazard if its producer has not yet reached the first
    // stage whose result can be forwarded to this consumer. Producers past
    // the last stage are already in the register file (write-before-read).
    assign w_rs_req = required_stage(w_rs_ld, id_is_branch, ALU_READY, LOAD_READY, BR_EXTRA);
    assign w_rt_req = required_stage(w_rt_ld, id_is_branch, ALU_READY, LOAD_READY, BR_EXTRA);
    assign w_rs_haz = w_rs_hit && (int'(w_rs_idx) < w_rs_req);
    assign w_rt_haz = w_rt_hit && (int'(w_rt_idx) < w_rt_req);
    assign w_haz    = id_valid && (w_rs_haz || w_rt_haz);

    assign stall_o    = w_haz | ext_stall;
    assign bubble_o   = w_haz & ~ext_stall;
    // A redirect seen during a stall is dropped; ID re-presents it afterwards
    assign flush_ifid = redirect & ~stall_o;
    assign w_accept   = id_valid & ~w_haz;

    always_comb begin
        fwd_rs_sel = c_sel_w'(c_fwd_rf);
        fwd_rt_sel = c_sel_w'(c_fwd_rf);
        if (!w_haz && w_rs_hit) begin
            fwd_rs_sel = c_sel_w'(w_rs_idx) + 1'b1;
        end
        if (!w_haz && w_rt_hit) begin
            fwd_rt_sel = c_sel_w'(w_rt_idx) + 1'b1;
        end
    end

    // Entry shift register; frozen entirely while downstream is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_wr_en   <= '0;
            r_is_load <= '0;
            r_rd      <= '0;
        end else if (!ext_stall) begin
            r_valid[c_stg_ex]   <= w_accept;
            r_wr_en[c_stg_ex]   <= w_accept & id_wr_en;
            r_is_load[c_stg_ex] <= w_accept & id_is_load;
            r_rd[c_stg_ex]      <= w_accept ? id_wr_rd : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_wr_en[k]   <= r_wr_en[k-1];
                r_is_load[k] <= r_is_load[k-1];
                r_rd[k]      <= r_rd[k-1];
            end
        end
    end

    // Saturating counters: hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bubble_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush_ifid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stage_valid = r_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule : pipeline_scoreboard
`default_nettype wire

// File: tb/tb_pipeline_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_scoreboard
//  Purpose  : Self-checking bench for pipeline_scoreboard. A cycle table of
//             ID inputs and expected outputs, then hand-written sequences for
//             counter saturation (narrow-counter instance) and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wr_en;
    logic [4:0] id_wr_rd;
    logic       id_is_load;
    logic       id_is_branch;
    logic       redirect;
    logic       ext_stall;

    logic        stall_o, bubble_o, flush_ifid;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [2:0]  stage_valid;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_o, s_bubble_o, s_flush_ifid;
    logic [1:0]  s_fwd_rs_sel, s_fwd_rt_sel;
    logic [2:0]  s_stage_valid;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_scoreboard u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_wr_en     (id_wr_en),
        .id_wr_rd     (id_wr_rd),
        .id_is_load   (id_is_load),
        .id_is_branch (id_is_branch),
        .redirect     (redirect),
        .ext_stall    (ext_stall),
        .stall_o      (stall_o),
        .bubble_o     (bubble_o),
        .flush_ifid   (flush_ifid),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .stage_valid  (stage_valid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Same stimulus, 2-bit counters to reach saturation quickly
    pipeline_scoreboard #(.CNT_W(2)) u_dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_wr_en     (id_wr_en),
        .id_wr_rd     (id_wr_rd),
        .id_is_load   (id_is_load),
        .id_is_branch (id_is_branch),
        .redirect     (redirect),
        .ext_stall    (ext_stall),
        .stall_o      (s_stall_o),
        .bubble_o     (s_bubble_o),
        .flush_ifid   (s_flush_ifid),
        .fwd_rs_sel   (s_fwd_rs_sel),
        .fwd_rt_sel   (s_fwd_rt_sel),
        .stage_valid  (s_stage_valid),
        .stall_cnt    (s_stall_cnt),
        .flush_cnt    (s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt;
        logic        urs, urt, we;
        logic [4:0]  rd;
        logic        ld, br, rdr, xs;
        logic        e_st, e_bb, e_fl;
        logic [1:0]  e_rs, e_rt;
        logic [2:0]  e_sv;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic we, input logic [4:0] rd,
        input logic ld, input logic br, input logic rdr, input logic xs,
        input logic e_st, input logic e_bb, input logic e_fl,
        input logic [1:0] e_rs, input logic [1:0] e_rt, input logic [2:0] e_sv,
        input logic [15:0] e_sc, input logic [15:0] e_fc
    );
        vec_t r;
        r.v = v;   r.rs = rs;   r.rt = rt;   r.urs = urs; r.urt = urt;
        r.we = we; r.rd = rd;   r.ld = ld;   r.br = br;   r.rdr = rdr; r.xs = xs;
        r.e_st = e_st; r.e_bb = e_bb; r.e_fl = e_fl;
        r.e_rs = e_rs; r.e_rt = e_rt; r.e_sv = e_sv; r.e_sc = e_sc; r.e_fc = e_fc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] rd, input logic ld, input logic br,
                         input logic rdr, input logic xs);
        id_valid = v;    id_rs = rs;       id_rt = rt;
        id_use_rs = urs; id_use_rt = urt;  id_wr_en = we;
        id_wr_rd = rd;   id_is_load = ld;  id_is_branch = br;
        redirect = rdr;  ext_stall = xs;
    endtask

    initial begin
        //             v  rs  rt urs urt we rd ld br rdr xs | st bb fl rs rt sv      sc fc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3'b000, 0, 0)); // reset state
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3'b000, 0, 0)); // lw $2
        tbl.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 0, 0, 0,   1, 1, 0, 0, 0, 3'b001, 0, 0)); // add $3,$2,$4 load-use
        tbl.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 0, 0, 0,   0, 0, 0, 2, 0, 3'b010, 1, 0)); // fwd from MEM
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3'b101, 1, 0)); // add $5
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0, 3'b011, 1, 0)); // beq on ALU in EX
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 1, 1, 0,   0, 0, 1, 2, 0, 3'b110, 2, 0)); // resolved + redirect
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3'b101, 2, 1)); // lw $5
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 3'b011, 2, 1)); // beq on load, 1st stall
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 3'b110, 3, 1)); // 2nd stall
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 1, 1, 0,   0, 0, 1, 3, 0, 3'b100, 4, 1)); // fwd from WB
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3'b001, 4, 2)); // sub $7
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3'b011, 4, 2)); // add $7
        tbl.push_back(mk(1, 7, 7, 1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 3'b111, 4, 2)); // youngest $7 wins
        tbl.push_back(mk(1, 0, 7, 1, 1, 1, 9, 0, 0, 0, 0,   0, 0, 0, 0, 2, 3'b111, 4, 2)); // $0 never forwards
        tbl.push_back(mk(1, 1, 0, 1, 0, 1,10, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3'b111, 4, 2)); // lw $10
        for (int i = 0; i < 4; i++)                                                          // ext_stall freeze
            tbl.push_back(mk(1,10, 9, 1, 1, 1,11, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3'b111, 4, 2));
        tbl.push_back(mk(1,10, 9, 1, 1, 1,11, 0, 0, 1, 0,   1, 1, 0, 0, 0, 3'b111, 4, 2)); // resume, load-use
        tbl.push_back(mk(1,10, 9, 1, 1, 1,11, 0, 0, 1, 0,   0, 0, 1, 2, 3, 3'b110, 5, 2)); // order kept

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].we,
                  tbl[i].rd, tbl[i].ld, tbl[i].br, tbl[i].rdr, tbl[i].xs);
            #1;
            chk($sformatf("r%0d stall_o", i),     32'(stall_o),     32'(tbl[i].e_st));
            chk($sformatf("r%0d bubble_o", i),    32'(bubble_o),    32'(tbl[i].e_bb));
            chk($sformatf("r%0d flush_ifid", i),  32'(flush_ifid),  32'(tbl[i].e_fl));
            chk($sformatf("r%0d fwd_rs_sel", i),  32'(fwd_rs_sel),  32'(tbl[i].e_rs));
            chk($sformatf("r%0d fwd_rt_sel", i),  32'(fwd_rt_sel),  32'(tbl[i].e_rt));
            chk($sformatf("r%0d stage_valid", i), 32'(stage_valid), 32'(tbl[i].e_sv));
            chk($sformatf("r%0d stall_cnt", i),   32'(stall_cnt),   32'(tbl[i].e_sc));
            chk($sformatf("r%0d flush_cnt", i),   32'(flush_cnt),   32'(tbl[i].e_fc));
        end

        // One more flush: 16-bit counter reaches 4, 2-bit counters stay pinned at 3
        @(negedge clk);
        drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        #1;
        chk("extra flush_ifid", 32'(flush_ifid), 32'd1);
        @(negedge clk);
        drive(1, 1, 0, 1, 0, 1, 12, 1, 0, 0, 0);   // lw $12
        #1;
        chk("flush_cnt after extra", 32'(flush_cnt),   32'd4);
        chk("sat flush_cnt",         32'(s_flush_cnt), 32'd3);
        chk("sat stall_cnt",         32'(s_stall_cnt), 32'd3);

        // Async reset in the middle of a load-use stall
        @(negedge clk);
        drive(1, 12, 12, 1, 1, 1, 13, 0, 0, 0, 0);  // add $13,$12,$12
        #1;
        chk("pre-reset stall_o", 32'(stall_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst stage_valid", 32'(stage_valid), 32'd0);
        chk("rst stall_o",     32'(stall_o),     32'd0);
        chk("rst bubble_o",    32'(bubble_o),    32'd0);
        chk("rst stall_cnt",   32'(stall_cnt),   32'd0);
        chk("rst flush_cnt",   32'(flush_cnt),   32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post-rst stall_o",    32'(stall_o),    32'd0);
        chk("post-rst fwd_rs_sel", 32'(fwd_rs_sel), 32'd0);
        @(negedge clk);
        #1;
        chk("post-rst stage_valid", 32'(stage_valid), 32'b001);
        chk("post-rst stall_cnt",   32'(stall_cnt),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipeline_scoreboard
`default_nettype wire
